// File: rtl/julia_iter_engine.sv
// julia_iter_engine: per-pixel Julia escape-time engine.
// Captures one Q16.16 coordinate z0 and iterates z <- z^2 + c at one step per clock.
// When z escapes or the iteration cap is reached, it reports the count with a
// single-cycle ready pulse.
// c is taken from a four-entry table; c_change steps through the table.
module julia_iter_engine #(
  parameter int          MAX_ITER   = 256,
  parameter int          SETTLE_CYC = 2,
  parameter logic [31:0] ESC_LIM    = 32'h0004_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c_change,
  input  logic [31:0] x_com,
  input  logic [31:0] y_com,
  output logic        ready,
  output logic [8:0]  fin_iter,
  output logic [1:0]  c_sel
);

  typedef enum logic [1:0] {S_SETTLE, S_LOAD, S_ITER, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         settle_cnt_q, settle_cnt_d;
  logic signed [31:0] zr_q, zr_d;
  logic signed [31:0] zi_q, zi_d;
  logic signed [31:0] cr_q, cr_d;
  logic signed [31:0] ci_q, ci_d;
  logic [8:0]         iter_q, iter_d;
  logic [8:0]         fin_iter_q, fin_iter_d;
  logic [1:0]         c_sel_q, c_sel_d;

  logic signed [31:0] tab_cr, tab_ci;
  logic signed [63:0] zr_sq_full, zi_sq_full, zrzi_full;
  logic signed [31:0] zr_sq, zi_sq, zrzi;
  logic [32:0]        mag;
  logic               escape_now;

  // Constant table of c values, indexed by the current selection.
  always_comb begin
    tab_cr = 32'sh0000_0000;
    tab_ci = 32'sh0000_0000;
    case (c_sel_q)
      2'd0: begin tab_cr = 32'shFFFF_3333; tab_ci = 32'sh0000_27F0; end
      2'd1: begin tab_cr = 32'sh0000_48F6; tab_ci = 32'sh0000_028F; end
      2'd2: begin tab_cr = 32'shFFFF_999A; tab_ci = 32'sh0000_999A; end
      default: begin tab_cr = 32'shFFFF_4C59; tab_ci = 32'shFFFF_9DA5; end
    endcase
  end

  // Q16.16 squares and cross product (bits [47:16] kept), magnitude, and the escape test.
  always_comb begin
    zr_sq_full = 64'(zr_q) * 64'(zr_q);
    zi_sq_full = 64'(zi_q) * 64'(zi_q);
    zrzi_full  = 64'(zr_q) * 64'(zi_q);
    zr_sq      = 32'(zr_sq_full >>> 16);
    zi_sq      = 32'(zi_sq_full >>> 16);
    zrzi       = 32'(zrzi_full >>> 16);
    mag        = {1'b0, zr_sq} + {1'b0, zi_sq};
    escape_now = (mag > {1'b0, ESC_LIM}) || (iter_q == 9'(MAX_ITER));
  end

  // State register plus the datapath flops, all cleared synchronously.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_SETTLE;
      settle_cnt_q <= '0;
      zr_q         <= '0;
      zi_q         <= '0;
      cr_q         <= '0;
      ci_q         <= '0;
      iter_q       <= '0;
      fin_iter_q   <= '0;
      c_sel_q      <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      zr_q         <= zr_d;
      zi_q         <= zi_d;
      cr_q         <= cr_d;
      ci_q         <= ci_d;
      iter_q       <= iter_d;
      fin_iter_q   <= fin_iter_d;
      c_sel_q      <= c_sel_d;
    end
  end

  // Next-state logic: settle, load the coordinate, iterate until exit, then report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_SETTLE: if (settle_cnt_q == 8'(SETTLE_CYC - 1)) state_d = S_LOAD;
      S_LOAD:   state_d = S_ITER;
      S_ITER:   if (escape_now) state_d = S_DONE;
      default:  state_d = S_SETTLE;
    endcase
  end

  // Datapath updates. c_sel steps in any state; the latched c changes only in LOAD.
  always_comb begin
    settle_cnt_d = '0;
    zr_d         = zr_q;
    zi_d         = zi_q;
    cr_d         = cr_q;
    ci_d         = ci_q;
    iter_d       = iter_q;
    fin_iter_d   = fin_iter_q;
    c_sel_d      = c_sel_q + {1'b0, c_change};
    case (state_q)
      S_SETTLE: begin
        if (settle_cnt_q != 8'(SETTLE_CYC - 1)) settle_cnt_d = settle_cnt_q + 8'd1;
      end
      S_LOAD: begin
        zr_d   = x_com;
        zi_d   = y_com;
        cr_d   = tab_cr;
        ci_d   = tab_ci;
        iter_d = '0;
      end
      S_ITER: begin
        if (escape_now) begin
          fin_iter_d = iter_q;
        end else begin
          zr_d   = zr_sq - zi_sq + cr_q;
          zi_d   = (zrzi <<< 1) + ci_q;
          iter_d = iter_q + 9'd1;
        end
      end
      default: ;
    endcase
  end

  // Output logic: ready is high for the single DONE cycle.
  always_comb begin
    ready    = (state_q == S_DONE);
    fin_iter = fin_iter_q;
    c_sel    = c_sel_q;
  end

endmodule

// File: tb/tb_julia_iter_engine.sv
// tb_julia_iter_engine: directed and randomized checks of julia_iter_engine.
// Expected escape counts come from a Q16.16 reference model of the iteration.
module tb_julia_iter_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_change;
  logic [31:0] x_com;
  logic [31:0] y_com;
  logic        ready;
  logic [8:0]  fin_iter;
  logic [1:0]  c_sel;

  int checks   = 0;
  int failures = 0;

  julia_iter_engine dut (
    .clk      (clk),
    .rst      (rst),
    .c_change (c_change),
    .x_com    (x_com),
    .y_com    (y_com),
    .ready    (ready),
    .fin_iter (fin_iter),
    .c_sel    (c_sel)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Reference escape-time model using 64-bit integer arithmetic.
  function automatic int juliaModel(input logic [31:0] x, input logic [31:0] y, input logic [1:0] sel);
    longint zr, zi, cr, ci, a, b, p;
    zr = longint'($signed(x));
    zi = longint'($signed(y));
    case (sel)
      2'd0: begin cr = -64'sd52429; ci = 64'sd10224; end
      2'd1: begin cr = 64'sd18678;  ci = 64'sd655;   end
      2'd2: begin cr = -64'sd26214; ci = 64'sd39322; end
      default: begin cr = -64'sd46023; ci = -64'sd25179; end
    endcase
    for (int n = 0; n <= 256; n++) begin
      a = longint'(int'((zr * zr) >>> 16));
      b = longint'(int'((zi * zi) >>> 16));
      p = longint'(int'((zr * zi) >>> 16));
      if ((a + b) > 64'sd262144 || n == 256) return n;
      zr = longint'(int'(a - b + cr));
      zi = longint'(int'(2 * p + ci));
    end
    return -1;
  endfunction

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point; counts the check and reports on mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Drive the coordinate that the next LOAD will capture.
  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
    x_com = x;
    y_com = y;
  endtask

  // Count edges until ready is sampled high, bounded by a cycle budget.
  task automatic waitReady(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (ready !== 1'b1 && cycles < 600);
    if (ready !== 1'b1) checkOutput("ready_timeout", 64'(ready), 64'd1);
  endtask

  // Pulse-width monitor: a sampled ready must be followed by a low sample.
  logic prev_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (prev_ready) checkOutput("ready_width", 64'(ready), 64'd0);
    prev_ready = ready;
  end

  int          cyc;
  int          exp0;
  int          expv;
  int          hold;
  int          rv;
  logic        saw_ready;
  logic [1:0]  sel_model;
  logic [31:0] rx, ry;

  // Linear directed sequence followed by a randomized sweep.
  initial begin
    rst = 1'b1;
    c_change = 1'b0;
    applyStimulus(32'h0, 32'h0);
    tick();
    tick();
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_fin", 64'(fin_iter), 64'd0);
    checkOutput("reset_csel", 64'(c_sel), 64'd0);
    rst = 1'b0;

    // z0 = 0 with c index 0, timed from reset release.
    exp0 = juliaModel(32'h0, 32'h0, 2'd0);
    waitReady(cyc);
    checkOutput("first_latency", 64'(cyc), 64'(exp0 + 4));
    checkOutput("first_fin", 64'(fin_iter), 64'(exp0));

    // 2.5i escapes immediately; the pixel period is 5 cycles.
    applyStimulus(32'h0, 32'h0002_8000);
    for (int k = 0; k < 3; k++) begin
      waitReady(cyc);
      checkOutput("esc0_period", 64'(cyc), 64'd5);
      checkOutput("esc0_fin", 64'(fin_iter), 64'd0);
    end

    // |z0|^2 = 4.0 exactly is not an escape; escapes one step later.
    applyStimulus(32'h0002_0000, 32'h0);
    waitReady(cyc);
    checkOutput("esc1_period", 64'(cyc), 64'd6);
    checkOutput("esc1_fin", 64'(fin_iter), 64'd1);
    applyStimulus(32'h0001_8000, 32'h0000_8000);
    tick();
    checkOutput("fin_hold", 64'(fin_iter), 64'd1);

    // c_change landing on the LOAD cycle leaves the captured c unchanged.
    tick();
    tick();
    c_change = 1'b1;
    tick();
    c_change = 1'b0;
    checkOutput("csel_step1", 64'(c_sel), 64'd1);
    expv = juliaModel(32'h0001_8000, 32'h0000_8000, 2'd0);
    waitReady(cyc);
    checkOutput("load_pulse_latency", 64'(cyc), 64'(expv + 1));
    checkOutput("load_pulse_fin", 64'(fin_iter), 64'(expv));
    expv = juliaModel(32'h0001_8000, 32'h0000_8000, 2'd1);
    waitReady(cyc);
    checkOutput("csel1_period", 64'(cyc), 64'(expv + 5));
    checkOutput("csel1_fin", 64'(fin_iter), 64'(expv));

    // Remaining pulses ten cycles apart: 2, 3, then wrap to 0.
    for (int k = 0; k < 3; k++) begin
      repeat (9) tick();
      c_change = 1'b1;
      tick();
      c_change = 1'b0;
      checkOutput("csel_step", 64'(c_sel), 64'((k + 2) % 4));
    end
    waitReady(cyc);
    expv = juliaModel(32'h0001_8000, 32'h0000_8000, 2'd0);
    waitReady(cyc);
    checkOutput("csel_wrap_period", 64'(cyc), 64'(expv + 5));
    checkOutput("csel_wrap_fin", 64'(fin_iter), 64'(expv));

    // Reset in the middle of a long z0 = 0 pixel aborts it without a ready pulse.
    applyStimulus(32'h0, 32'h0);
    tick();
    tick();
    tick();
    tick();
    hold = (exp0 > 100) ? 100 : exp0 / 2;
    saw_ready = 1'b0;
    c_change = 1'b1;
    for (int k = 0; k < hold; k++) begin
      tick();
      c_change = 1'b0;
      if (ready === 1'b1) saw_ready = 1'b1;
    end
    checkOutput("pre_reset_csel", 64'(c_sel), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_no_ready", 64'(saw_ready), 64'd0);
    checkOutput("abort_ready", 64'(ready), 64'd0);
    checkOutput("abort_fin", 64'(fin_iter), 64'd0);
    checkOutput("abort_csel", 64'(c_sel), 64'd0);
    waitReady(cyc);
    checkOutput("restart_latency", 64'(cyc), 64'(exp0 + 4));
    checkOutput("restart_fin", 64'(fin_iter), 64'(exp0));

    // Randomized z0 in [-2,2]^2 with random c steps between pixels.
    sel_model = 2'd0;
    for (int i = 0; i < 150; i++) begin
      rv = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
      rx = 32'(rv);
      rv = int'($urandom_range(0, 32'h0004_0000)) - 32'sh0002_0000;
      ry = 32'(rv);
      applyStimulus(rx, ry);
      c_change = 1'($urandom_range(0, 1));
      sel_model = sel_model + {1'b0, c_change};
      tick();
      c_change = 1'b0;
      expv = juliaModel(rx, ry, sel_model);
      waitReady(cyc);
      checkOutput("rand_period", 64'(cyc + 1), 64'(expv + 5));
      checkOutput("rand_fin", 64'(fin_iter), 64'(expv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
